// File: rtl/sound_mixer.sv
// Priority mixer for the sound-effect generators: the lowest-index active
// channel owns the single speaker pin, and its square wave is gated by a PWM volume.
module sound_mixer #(
  parameter int NUM_CH         = 4,
  parameter int SILENCE_CYCLES = 262144
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] soundIn,
  input  logic [1:0]        volume,
  output logic              speakerOut,
  output logic              busy,
  output logic [1:0]        owner
);

  // One extra bit so the counter can hold SILENCE_CYCLES itself when it is a power of two.
  localparam int CW = $clog2(SILENCE_CYCLES + 1);
  localparam logic [CW-1:0] SIL = CW'(SILENCE_CYCLES);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state;
  logic [NUM_CH-1:0] sound_q;
  logic [NUM_CH-1:0] seen;
  logic [NUM_CH-1:0] active;
  logic [CW-1:0]     silence_cnt [NUM_CH];
  logic [7:0]        pwm_cnt;
  logic              gate;
  logic              any_active;
  logic [1:0]        lowest;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = seen[i] && (silence_cnt[i] < SIL);
    end
  end

  // Scanning from the top down leaves the lowest active index in lowest.
  always_comb begin
    lowest     = 2'd0;
    any_active = |active;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active[i]) lowest = 2'(i);
    end
  end

  always_comb begin
    gate = 1'b0;
    case (volume)
      2'd0: gate = 1'b0;
      2'd1: gate = (pwm_cnt < 8'd64);
      2'd2: gate = (pwm_cnt < 8'd128);
      2'd3: gate = 1'b1;
      default: gate = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sound_q <= '0;
      seen    <= '0;
      for (int i = 0; i < NUM_CH; i++) silence_cnt[i] <= SIL;
    end else begin
      sound_q <= soundIn;
      for (int i = 0; i < NUM_CH; i++) begin
        if (soundIn[i] != sound_q[i]) begin
          silence_cnt[i] <= '0;
          seen[i]        <= 1'b1;
        end else if (silence_cnt[i] < SIL) begin
          silence_cnt[i] <= silence_cnt[i] + CW'(1);
        end else begin
          seen[i] <= 1'b0;
        end
      end
    end
  end

  // Preemption is tested before owner loss so a simultaneous handover skips IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      speakerOut <= 1'b0;
      pwm_cnt    <= 8'd0;
    end else begin
      pwm_cnt    <= pwm_cnt + 8'd1;
      speakerOut <= (state == PLAY) && sound_q[owner] && gate;
      case (state)
        IDLE: begin
          if (any_active) begin
            owner <= lowest;
            state <= PLAY;
          end
        end
        PLAY: begin
          if (any_active && (lowest < owner)) begin
            owner <= lowest;
          end else if (!active[owner]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == PLAY);

endmodule

// File: tb/tb_sound_mixer.sv
// Randomised and directed stimulus for sound_mixer, checked cycle by cycle
// against a timestamp-based reference model through an expected-value queue.
module tb_sound_mixer;

  localparam int SIL   = 16;
  localparam int NEVER = -1000000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] soundIn;
  logic [1:0] volume;
  logic       speakerOut;
  logic       busy;
  logic [1:0] owner;

  sound_mixer #(.NUM_CH(4), .SILENCE_CYCLES(SIL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .soundIn    (soundIn),
    .volume     (volume),
    .speakerOut (speakerOut),
    .busy       (busy),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       spk;
    logic       busy;
    logic [1:0] own;
    logic       chk_own;
  } exp_t;

  exp_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model: each channel remembers the cycle of its last detected edge.
  int         m_now = 0;
  int         m_last [4];
  logic [3:0] m_prev = 4'd0;
  bit         m_play = 1'b0;
  logic [1:0] m_own  = 2'd0;
  int         m_pwm  = 0;

  logic [3:0] cur_in;
  logic [1:0] cur_vol;
  logic [3:0] mask;

  initial begin
    for (int i = 0; i < 4; i++) m_last[i] = NEVER;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] in_v, input logic [1:0] vol_v, input logic rst_v);
    exp_t e;
    bit   act [4];
    bit   any;
    int   low;
    bit   g;
    @(negedge clk);
    soundIn = in_v;
    volume  = vol_v;
    reset_n = rst_v;
    m_now++;
    if (!rst_v) begin
      m_play = 1'b0;
      m_own  = 2'd0;
      m_prev = 4'd0;
      m_pwm  = 0;
      for (int i = 0; i < 4; i++) m_last[i] = NEVER;
      e = '{spk: 1'b0, busy: 1'b0, own: 2'd0, chk_own: 1'b1};
    end else begin
      any = 1'b0;
      low = 4;
      for (int i = 3; i >= 0; i--) begin
        act[i] = (m_now - 1 - m_last[i]) < SIL;
        if (act[i]) begin any = 1'b1; low = i; end
      end
      case (vol_v)
        2'd0: g = 1'b0;
        2'd1: g = m_pwm < 64;
        2'd2: g = m_pwm < 128;
        default: g = 1'b1;
      endcase
      e.spk = m_play && m_prev[m_own] && g;
      if (!m_play) begin
        if (any) begin m_play = 1'b1; m_own = 2'(low); end
      end else if (any && low < int'(m_own)) begin
        m_own = 2'(low);
      end else if (!act[m_own]) begin
        m_play = 1'b0;
      end
      for (int i = 0; i < 4; i++) if (in_v[i] != m_prev[i]) m_last[i] = m_now;
      m_prev    = in_v;
      m_pwm     = (m_pwm + 1) % 256;
      e.busy    = m_play;
      e.own     = m_own;
      e.chk_own = m_play;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("speakerOut", int'(speakerOut), int'(e.spk));
        checkOutput("busy", int'(busy), int'(e.busy));
        if (e.chk_own) checkOutput("owner", int'(owner), int'(e.own));
      end
    end
  end

  initial begin : driver
    soundIn = 4'd0;
    volume  = 2'd3;
    reset_n = 1'b0;
    cur_in  = 4'd0;
    cur_vol = 2'd3;
    $display("[TB] reset");
    repeat (3) applyStimulus(4'd0, 2'd3, 1'b0);

    $display("[TB] channel 2 alone at full volume");
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 0) cur_in[2] = ~cur_in[2];
      applyStimulus(cur_in, 2'd3, 1'b1);
    end

    $display("[TB] channel 0 preempts channel 2");
    for (int c = 0; c < 30; c++) begin
      if (c % 4 == 0) cur_in[2] = ~cur_in[2];
      if (c % 3 == 0) cur_in[0] = ~cur_in[0];
      applyStimulus(cur_in, 2'd3, 1'b1);
    end

    $display("[TB] channel 0 falls silent, channel 2 resumes");
    for (int c = 0; c < 40; c++) begin
      if (c % 4 == 0) cur_in[2] = ~cur_in[2];
      applyStimulus(cur_in, 2'd3, 1'b1);
    end

    $display("[TB] channel 1 held high at volume 2, then volume 0");
    cur_in[1] = 1'b1;
    for (int c = 0; c < 24; c++) applyStimulus(cur_in, 2'd2, 1'b1);
    cur_in[1] = 1'b0;
    applyStimulus(cur_in, 2'd2, 1'b1);
    cur_in[1] = 1'b1;
    for (int c = 0; c < 22; c++) applyStimulus(cur_in, 2'd0, 1'b1);
    cur_in[1] = 1'b0;
    applyStimulus(cur_in, 2'd1, 1'b1);
    cur_in[1] = 1'b1;
    for (int c = 0; c < 22; c++) applyStimulus(cur_in, 2'd1, 1'b1);

    $display("[TB] randomised traffic");
    mask = 4'd0;
    for (int c = 0; c < 500; c++) begin
      if (c % 50 == 0) mask = 4'($urandom);
      if (c % 20 == 0) cur_vol = 2'($urandom_range(3));
      for (int i = 0; i < 4; i++)
        if (mask[i] && $urandom_range(3) == 0) cur_in[i] = ~cur_in[i];
      applyStimulus(cur_in, cur_vol, ($urandom_range(99) == 0) ? 1'b0 : 1'b1);
    end

    $display("[TB] reset in the middle of playback");
    cur_in = 4'd0;
    applyStimulus(cur_in, 2'd3, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c % 2 == 0) cur_in[3] = ~cur_in[3];
      applyStimulus(cur_in, 2'd3, 1'b1);
    end
    cur_in = 4'd0;
    applyStimulus(cur_in, 2'd3, 1'b0);
    for (int c = 0; c < 30; c++) applyStimulus(cur_in, 2'd3, 1'b1);

    $display("[TB] all channels go silent");
    for (int c = 0; c < 20; c++) begin
      cur_in = cur_in ^ 4'($urandom);
      applyStimulus(cur_in, 2'd3, 1'b1);
    end
    for (int c = 0; c < 30; c++) applyStimulus(cur_in, 2'd3, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
